hd44780_cmd_arbiter: RTL and testbench

- Shares one hd44780_controller, and through it the instruction RAM, among NUM_REQ independent requesters. Each requester owns a command sequence starting at its own RAM address.
- Picks one pending requester by round-robin and issues a single-cycle STB_I with that requester's start address. It then tracks the controller's busy/error handshake and returns a per-requester done/error pulse.
- Sits between client logic (display-update FSMs, status writers) and the controller's STB_I / i_start_addr / busy / error pins.

---
 rtl/hd44780_cmd_arbiter_pkg.sv | 24 ++
 rtl/hd44780_cmd_arbiter_rr_picker.sv | 29 ++
 rtl/hd44780_cmd_arbiter.sv | 158 +++++++++++++++
 tb/tb_hd44780_cmd_arbiter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/hd44780_cmd_arbiter_pkg.sv
// Shared types and helpers for the HD44780 command arbiter.
package hd44780_cmd_arbiter_pkg;

  localparam int unsigned DEF_NUM_REQ    = 4;
  localparam int unsigned DEF_RAM_AWIDTH = 8;
  localparam int unsigned DEF_BUSY_WAIT  = 15;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_STROBE    = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_RUN       = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  // ceil(log2(v)) with a floor of 1 so single-value ranges still get a bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/hd44780_cmd_arbiter_rr_picker.sv
// Round-robin winner search: first asserted request after last_i, wrapping.
module hd44780_cmd_arbiter_rr_picker
  import hd44780_cmd_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned IDX_W   = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [IDX_W-1:0]   win_idx_o,
  output logic               valid_o
);

  int unsigned cand;

  always_comb begin
    win_idx_o = '0;
    valid_o   = 1'b0;
    cand      = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = (32'(last_i) + i) % NUM_REQ;
      if (!valid_o && req_i[cand[IDX_W-1:0]]) begin
        valid_o   = 1'b1;
        win_idx_o = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/hd44780_cmd_arbiter.sv
// Shares one hd44780_controller among NUM_REQ requesters: round-robin grant,
// single-cycle strobe, busy/error handshake tracking, per-requester done/err.
module hd44780_cmd_arbiter
  import hd44780_cmd_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned ram_awidth = DEF_RAM_AWIDTH,
  parameter int unsigned BUSY_WAIT  = DEF_BUSY_WAIT
) (
  input  logic                          CLK_I,
  input  logic                          RST_I,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*ram_awidth-1:0] i_start_addrs,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic [NUM_REQ-1:0]            o_done,
  output logic [NUM_REQ-1:0]            o_err,
  output logic                          o_ctrl_stb,
  output logic [ram_awidth-1:0]         o_ctrl_start_addr,
  input  logic                          i_ctrl_busy,
  input  logic                          i_ctrl_error,
  output logic                          o_busy
);

  localparam int unsigned IDX_W = clog2_min1(NUM_REQ);
  localparam int unsigned CNT_W = clog2_min1(BUSY_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BUSY_WAIT);
  localparam logic [IDX_W-1:0] RR_RESET = IDX_W'(NUM_REQ - 1);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [IDX_W-1:0]        rr_q, rr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        cnt_inc;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [NUM_REQ-1:0]      done_q, done_d;
  logic [NUM_REQ-1:0]      err_q, err_d;
  logic                    stb_q, stb_d;
  logic                    busy_q, busy_d;
  logic [ram_awidth-1:0]   addr_q, addr_d;
  logic [ram_awidth-1:0]   addr_sel;
  logic [IDX_W-1:0]        win_idx;
  logic                    win_valid;

  hd44780_cmd_arbiter_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i     (i_req),
    .last_i    (rr_q),
    .win_idx_o (win_idx),
    .valid_o   (win_valid)
  );

  // Start-address slice of the current round-robin winner.
  always_comb begin
    addr_sel = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (win_idx == IDX_W'(k)) addr_sel = i_start_addrs[k*ram_awidth +: ram_awidth];
    end
  end

  // Saturating timeout increment.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    done_d  = '0;
    err_d   = '0;
    stb_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Controller busy here means power-on init or a foreign sequence.
        if (win_valid && !i_ctrl_busy) begin
          state_d = ST_STROBE;
          idx_d   = win_idx;
          grant_d = NUM_REQ'(1) << win_idx;
          addr_d  = addr_sel;
          stb_d   = 1'b1;
        end
      end
      ST_STROBE: begin
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (i_ctrl_busy) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            state_d = ST_DONE;
            done_d  = grant_q;
            err_d   = grant_q;
          end
        end
      end
      ST_RUN: begin
        if (!i_ctrl_busy) begin
          state_d = ST_DONE;
          done_d  = grant_q;
          err_d   = i_ctrl_error ? grant_q : '0;
        end
      end
      ST_DONE: begin
        rr_d    = idx_q;
        grant_d = '0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      rr_q    <= RR_RESET;
      cnt_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      stb_q   <= stb_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
    end
  end

  assign o_grant           = grant_q;
  assign o_done            = done_q;
  assign o_err             = err_q;
  assign o_ctrl_stb        = stb_q;
  assign o_ctrl_start_addr = addr_q;
  assign o_busy            = busy_q;

endmodule

// File: tb/tb_hd44780_cmd_arbiter.sv
// Bench for hd44780_cmd_arbiter: directed and randomized transactions checked
// against a transaction-level round-robin and handshake-timing model.
module tb_hd44780_cmd_arbiter;

  localparam int BW = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  i_req;
  logic [31:0] addrs;
  logic [3:0]  o_grant, o_done, o_err;
  logic        o_ctrl_stb;
  logic [7:0]  o_ctrl_start_addr;
  logic        i_ctrl_busy, i_ctrl_error;
  logic        o_busy;

  int vectors = 0;
  int miscompares = 0;
  int rr_m = 3;

  always #5 clk = ~clk;

  hd44780_cmd_arbiter #(.NUM_REQ(4), .ram_awidth(8), .BUSY_WAIT(BW)) dut (
    .CLK_I             (clk),
    .RST_I             (rst_n),
    .i_req             (i_req),
    .i_start_addrs     (addrs),
    .o_grant           (o_grant),
    .o_done            (o_done),
    .o_err             (o_err),
    .o_ctrl_stb        (o_ctrl_stb),
    .o_ctrl_start_addr (o_ctrl_start_addr),
    .i_ctrl_busy       (i_ctrl_busy),
    .i_ctrl_error      (i_ctrl_error),
    .o_busy            (o_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first requester above the last winner, wrapping.
  function automatic int pick(input logic [3:0] r, input int last);
    for (int i = 1; i <= 4; i++) begin
      if (r[(last + i) % 4]) return (last + i) % 4;
    end
    return -1;
  endfunction

  task automatic wait_stb(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (o_ctrl_stb === 1'b1) seen = 1'b1;
    end
    chk("strobe_seen", 32'(seen), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(o_grant), 32'd0);
    chk({tag, "_done"},  32'(o_done),  32'd0);
    chk({tag, "_err"},   32'(o_err),   32'd0);
    chk({tag, "_stb"},   32'(o_ctrl_stb), 32'd0);
    chk({tag, "_addr"},  32'(o_ctrl_start_addr), 32'd0);
    chk({tag, "_busy"},  32'(o_busy),  32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; i_req = '0; i_ctrl_busy = 1'b0; i_ctrl_error = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    rr_m = 3;
  endtask

  // One transaction. Controller model: busy high for t in [d, d+len) after
  // the strobe cycle t=0, error pulsed when busy falls; 'never' keeps it idle.
  task automatic run_txn(input logic [3:0] req, input int d, input int len,
                         input bit err_end, input bit never, input bit drop);
    int w, t_done;
    bit seen;
    logic [3:0] oh;
    logic [7:0] exp_addr;
    i_req = req;
    w = pick(req, rr_m);
    oh = 4'(1 << w);
    exp_addr = addrs[w*8 +: 8];
    wait_stb(seen);
    if (!seen) return;
    t_done = never ? BW + 1 : d + len + 1;
    for (int t = 0; t <= t_done + 1; t++) begin
      if (t > 0) @(negedge clk);
      chk("stb",   32'(o_ctrl_stb), 32'(t == 0));
      chk("done",  32'(o_done), (t == t_done) ? 32'(oh) : 32'd0);
      chk("err",   32'(o_err), (t == t_done && (never || err_end)) ? 32'(oh) : 32'd0);
      chk("grant", 32'(o_grant), (t <= t_done) ? 32'(oh) : 32'd0);
      chk("busy",  32'(o_busy), 32'(t <= t_done));
      if (t <= t_done) chk("addr", 32'(o_ctrl_start_addr), 32'(exp_addr));
      i_ctrl_busy  = !never && t >= d && t < d + len;
      i_ctrl_error = err_end && !never && t == d + len;
      if (drop && t == 1) i_req = '0;
    end
    rr_m = w;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst_n = 1'b0; i_req = '0; i_ctrl_busy = 1'b0; i_ctrl_error = 1'b0;
    addrs = 32'h7C_40_21_10;
    do_reset();

    // Controller still initialising: no strobe while busy.
    i_ctrl_busy = 1'b1;
    i_req = 4'b0001;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      chk("init_stb", 32'(o_ctrl_stb), 32'd0);
      chk("init_grant", 32'(o_grant), 32'd0);
    end
    i_ctrl_busy = 1'b0;
    run_txn(4'b0001, 3, 10, 1'b0, 1'b0, 1'b1);

    // Single request with address 0x40.
    run_txn(4'b0100, 2, 50, 1'b0, 1'b0, 1'b1);
    // Timeout, then controller error, then a normal follow-up.
    run_txn(4'b0010, 0, 0, 1'b0, 1'b1, 1'b1);
    run_txn(4'b1000, 4, 6, 1'b1, 1'b0, 1'b1);
    run_txn(4'b0001, 1, 3, 1'b0, 1'b0, 1'b1);
    // Busy rises on the last allowed cycle.
    run_txn(4'b0010, BW, 2, 1'b0, 1'b0, 1'b1);

    // Held requests rotate 0,1,3 from a fresh reset.
    do_reset();
    for (int n = 0; n < 6; n++) run_txn(4'b1011, 2, 3, 1'b0, 1'b0, 1'b0);
    i_req = '0;

    // Randomized traffic.
    for (int n = 0; n < 16; n++) begin
      addrs = $urandom();
      run_txn(4'($urandom_range(1, 15)), int'($urandom_range(1, BW)),
              int'($urandom_range(1, 8)), $urandom_range(0, 3) == 0,
              $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)));
    end
    i_req = '0;

    // Asynchronous reset while the controller is running.
    @(negedge clk);
    i_req = 4'b0100;
    wait_stb(seen);
    i_ctrl_busy = 1'b1;
    repeat (5) @(negedge clk);
    chk("run_busy", 32'(o_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    @(posedge clk);
    #1 chk("async_rst_nodone", 32'(o_done), 32'd0);
    @(negedge clk);
    i_ctrl_busy = 1'b0;
    i_req = 4'b0101;
    rst_n = 1'b1;
    rr_m = 3;
    run_txn(4'b0101, 2, 4, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
